// File: rtl/light_countdown_timer.sv
// light_countdown_timer: counts the traffic-light FSM's current phase down on a
// 1 Hz tick derived from clk, and pulses last_light when the phase expires.
// Optional BCD outputs (bcd_tens/bcd_ones) are enabled by defining LIGHT_TIMER_BCD_EN.
module light_countdown_timer #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] time_light,
  output logic             last_light,
  output logic [WIDTH-1:0] count,
  output logic             tick
`ifdef LIGHT_TIMER_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } timer_state_t;

  timer_state_t     fsm_q, fsm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             last_q, last_d;
  logic [1:0]       prev_q;
  logic             load;
  logic             tick_int;

  // Next-state logic: a load overrides any tick in the same cycle; DONE blocks
  // counting so the FSM cannot be advanced twice while its new state settles.
  always_comb begin
    load     = (state != prev_q);
    tick_int = en && (fsm_q == RUN) && (presc_q == PRESC_MAX);
    count_d  = count_q;
    presc_d  = presc_q;
    fsm_d    = fsm_q;
    tick_d   = 1'b0;
    last_d   = 1'b0;
    if (load) begin
      count_d = time_light;
      presc_d = '0;
      fsm_d   = RUN;
    end else if (en && (fsm_q == RUN)) begin
      tick_d = tick_int;
      if (tick_int) begin
        presc_d = '0;
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          last_d  = 1'b1;
          fsm_d   = DONE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

`ifdef LIGHT_TIMER_BCD_EN
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [31:0] count_wide;

  // Decode the next count so the digits change on the same edge as count.
  always_comb begin
    count_wide = 32'(count_d);
    tens_d     = 4'(count_wide / 32'd10);
    ones_d     = 4'(count_wide % 32'd10);
  end

  // BCD digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= RUN;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      last_q  <= 1'b0;
      prev_q  <= 2'b00;
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      last_q  <= last_d;
      prev_q  <= state;
    end
  end

  assign last_light = last_q;
  assign count      = count_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_light_countdown_timer.sv
// Directed testbench for light_countdown_timer (WIDTH=5, TICK_DIV=4).
module tb_light_countdown_timer;

  localparam int unsigned W  = 5;
  localparam int unsigned TD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   state;
  logic [W-1:0] time_light;
  logic         last_light;
  logic [W-1:0] count;
  logic         tick;
`ifdef LIGHT_TIMER_BCD_EN
  logic [3:0]   bcd_tens;
  logic [3:0]   bcd_ones;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  light_countdown_timer #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .state      (state),
    .time_light (time_light),
    .last_light (last_light),
    .count      (count),
    .tick       (tick)
`ifdef LIGHT_TIMER_BCD_EN
    ,
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hit;
    int cnt;

    rst = 1'b1; en = 1'b0; state = 2'b00; time_light = '0;
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_last", 32'(last_light), 0);
`ifdef LIGHT_TIMER_BCD_EN
    check("rst_bcd_tens", 32'(bcd_tens), 0);
    check("rst_bcd_ones", 32'(bcd_ones), 0);
`endif

    // Startup: IDLE with count 0 expires on the first tick.
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        check("startup_last_quiet", 32'(last_light), 0);
        check("startup_tick_quiet", 32'(tick), 0);
      end else begin
        check("startup_last", 32'(last_light), 1);
        check("startup_tick", 32'(tick), 1);
        check("startup_count", 32'(count), 0);
      end
    end
    step();
    check("startup_last_single", 32'(last_light), 0);
    check("startup_tick_single", 32'(tick), 0);

    // RED phase of 18 s: pulse 73 cycles after the state change.
    state = 2'b01; time_light = W'(18);
    hit = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 1) check("load18_count", 32'(count), 18);
      if (n == 5) check("first_dec_count", 32'(count), 17);
      if (last_light) begin
        hit = n;
        break;
      end
    end
    check("pulse_latency", 32'(hit), 73);
    check("expire_count", 32'(count), 0);
    step();
    check("pulse_single", 32'(last_light), 0);

    // DONE: no second pulse while state holds.
    cnt = 0;
    repeat (20) begin
      step();
      if (last_light) cnt++;
    end
    check("done_no_pulse", 32'(cnt), 0);
    check("done_count", 32'(count), 0);

    // GREEN 15 s resumes counting.
    state = 2'b10; time_light = W'(15);
    step();
    check("load15_count", 32'(count), 15);
    repeat (3) step();
    check("load15_hold", 32'(count), 15);
    step();
    check("load15_dec", 32'(count), 14);
    repeat (29) step();
    check("reach7_count", 32'(count), 7);

    // en low mid-count (prescaler at 1): everything holds.
    en = 1'b0;
    cnt = 0;
    repeat (10) begin
      step();
      if (tick) cnt++;
    end
    check("en0_no_tick", 32'(cnt), 0);
    check("en0_count", 32'(count), 7);
    en = 1'b1;
    step(); step();
    check("en1_count_hold", 32'(count), 7);
    check("en1_tick_quiet", 32'(tick), 0);
    step();
    check("en1_count_dec", 32'(count), 6);
    check("en1_tick", 32'(tick), 1);

    // Reset mid-count at 9.
    state = 2'b11; time_light = W'(9);
    step();
    check("load9_count", 32'(count), 9);
`ifdef LIGHT_TIMER_BCD_EN
    check("load9_bcd_tens", 32'(bcd_tens), 0);
    check("load9_bcd_ones", 32'(bcd_ones), 9);
`endif
    rst = 1'b1;
    step();
    check("midrst_count", 32'(count), 0);
    check("midrst_last", 32'(last_light), 0);
    check("midrst_tick", 32'(tick), 0);
`ifdef LIGHT_TIMER_BCD_EN
    check("midrst_bcd_tens", 32'(bcd_tens), 0);
    check("midrst_bcd_ones", 32'(bcd_ones), 0);
`endif

    // Load 18 after reset, then 9 ticks down to 9.
    rst = 1'b0; state = 2'b01; time_light = W'(18);
    step();
    check("reload18_count", 32'(count), 18);
`ifdef LIGHT_TIMER_BCD_EN
    check("bcd18_tens", 32'(bcd_tens), 1);
    check("bcd18_ones", 32'(bcd_ones), 8);
`endif
    repeat (36) step();
    check("nine_ticks_count", 32'(count), 9);
`ifdef LIGHT_TIMER_BCD_EN
    check("bcd9_tens", 32'(bcd_tens), 0);
    check("bcd9_ones", 32'(bcd_ones), 9);
`endif

    // Load coinciding with a tick: load wins.
    repeat (3) step();
    state = 2'b10; time_light = W'(12);
    step();
    check("load_vs_tick_count", 32'(count), 12);
    check("load_vs_tick_tick", 32'(tick), 0);
    check("load_vs_tick_last", 32'(last_light), 0);
    repeat (3) step();
    check("after_load12_hold", 32'(count), 12);
    step();
    check("after_load12_dec", 32'(count), 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
